// File: rtl/floo_order_mon_pkg.sv
// Shared types for the AXI order monitor: error codes, counter width and the
// default monitored request/response structs.
package floo_order_mon_pkg;

    localparam int unsigned NumCntWidth = 32;
    localparam int unsigned DefIdWidth  = 4;
    localparam int unsigned LenWidth    = 8;

    typedef enum logic [2:0] {
        NONE           = 3'd0,
        R_UNEXPECTED   = 3'd1,
        R_LAST_EARLY   = 3'd2,
        R_LAST_MISSING = 3'd3,
        B_UNEXPECTED   = 3'd4,
        OVERFLOW       = 3'd5,
        TIMEOUT        = 3'd6
    } err_e;

    typedef struct packed {
        logic [DefIdWidth-1:0] id;
        logic [LenWidth-1:0]   len;
    } mon_ar_t;

    typedef struct packed {
        logic [DefIdWidth-1:0] id;
    } mon_aw_t;

    typedef struct packed {
        logic [DefIdWidth-1:0] id;
        logic                  last;
    } mon_r_t;

    typedef struct packed {
        logic [DefIdWidth-1:0] id;
    } mon_b_t;

    typedef struct packed {
        mon_ar_t ar;
        mon_aw_t aw;
        logic    ar_valid;
        logic    aw_valid;
        logic    r_ready;
        logic    b_ready;
    } mon_req_t;

    typedef struct packed {
        mon_r_t r;
        mon_b_t b;
        logic   ar_ready;
        logic   aw_ready;
        logic   r_valid;
        logic   b_valid;
    } mon_rsp_t;

    // Completion counters stick at all-ones instead of wrapping.
    function automatic logic [NumCntWidth-1:0] sat_inc(input logic [NumCntWidth-1:0] value);
        return (&value) ? value : value + NumCntWidth'(1);
    endfunction

endpackage

// File: rtl/floo_order_mon_len_fifo.sv
// Per-ID FIFO of outstanding AR burst lengths; pointers carry an extra wrap bit
// so that full and empty are distinguished. Push and pop may coincide when full.
module floo_order_mon_len_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

    logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
    logic [Width-1:0]  mem_q [Depth];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
    end

endmodule

// File: rtl/floo_axi_order_monitor.sv
// Per-ID AXI ordering/progress monitor with sticky first-error capture.
// Optional stall watchdog built when FLOO_ORDER_MON_TIMEOUT_EN is defined.
module floo_axi_order_monitor
    import floo_order_mon_pkg::*;
#(
    parameter int unsigned IdWidth       = 4,
    parameter int unsigned MaxTxnsPerId  = 8,
    parameter int unsigned TimeoutCycles = 1024,
    parameter type         req_t         = mon_req_t,
    parameter type         rsp_t         = mon_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  req_t                   req_i,
    input  rsp_t                   rsp_i,
    output logic                   err_o,
    output err_e                   err_code_o,
    output logic [IdWidth-1:0]     err_id_o,
    output logic [NumCntWidth-1:0] num_reads_o,
    output logic [NumCntWidth-1:0] num_writes_o,
    output logic                   idle_o,
    output logic                   timeout_o
);

    localparam int unsigned NumIds = 2 ** IdWidth;
    localparam int unsigned CntW   = $clog2(MaxTxnsPerId) + 1;
    localparam int unsigned TotW   = $clog2(2 * NumIds * MaxTxnsPerId + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTxnsPerId);

    logic [IdWidth-1:0] ar_id, aw_id, r_id, b_id;
    logic ar_hs, aw_hs, r_hs, b_hs;
    logic [NumIds-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [LenWidth-1:0] fifo_head [NumIds];
    logic [LenWidth-1:0] beat_q [NumIds];
    logic [CntW-1:0]     wr_cnt_q [NumIds];
    logic [TotW-1:0]     total_q, total_d;

    logic r_empty, r_unexp, r_early, r_missing, r_pop, r_done;
    logic ovf_ar, rd_push, b_unexp, b_dec, ovf_aw, aw_inc, timeout_ev;
    logic [LenWidth-1:0] r_len, r_beat;

    logic               err_q, ev_valid;
    err_e               err_code_q, ev_code;
    logic [IdWidth-1:0] err_id_q, ev_id;
    logic [NumCntWidth-1:0] num_reads_q, num_writes_q;
    logic idle_q;

    assign ar_id = IdWidth'(req_i.ar.id);
    assign aw_id = IdWidth'(req_i.aw.id);
    assign r_id  = IdWidth'(rsp_i.r.id);
    assign b_id  = IdWidth'(rsp_i.b.id);
    assign ar_hs = req_i.ar_valid & rsp_i.ar_ready;
    assign aw_hs = req_i.aw_valid & rsp_i.aw_ready;
    assign r_hs  = rsp_i.r_valid & req_i.r_ready;
    assign b_hs  = rsp_i.b_valid & req_i.b_ready;

    // An erroneous R beat still retires the head entry so checking resynchronises.
    assign r_empty   = fifo_empty[r_id];
    assign r_len     = fifo_head[r_id];
    assign r_beat    = beat_q[r_id];
    assign r_unexp   = r_hs & r_empty;
    assign r_early   = r_hs & ~r_empty & rsp_i.r.last & (r_beat != r_len);
    assign r_missing = r_hs & ~r_empty & ~rsp_i.r.last & (r_beat == r_len);
    assign r_done    = r_hs & ~r_empty & rsp_i.r.last & (r_beat == r_len);
    assign r_pop     = r_hs & ~r_empty & (rsp_i.r.last | r_missing);

    assign ovf_ar  = ar_hs & fifo_full[ar_id] & ~(r_pop & (r_id == ar_id));
    assign rd_push = ar_hs & ~ovf_ar;
    assign b_unexp = b_hs & (wr_cnt_q[b_id] == '0);
    assign b_dec   = b_hs & ~b_unexp;
    assign ovf_aw  = aw_hs & (wr_cnt_q[aw_id] == CntMax) & ~(b_dec & (b_id == aw_id));
    assign aw_inc  = aw_hs & ~ovf_aw;

    for (genvar i = 0; i < NumIds; i++) begin : gen_fifo
        assign fifo_push[i] = rd_push & (ar_id == IdWidth'(i));
        assign fifo_pop[i]  = r_pop & (r_id == IdWidth'(i));

        floo_order_mon_len_fifo #(
            .Depth(MaxTxnsPerId),
            .Width(LenWidth)
        ) i_len_fifo (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clear_i(clear_i),
            .push_i (fifo_push[i]),
            .data_i (req_i.ar.len),
            .pop_i  (fifo_pop[i]),
            .full_o (fifo_full[i]),
            .empty_o(fifo_empty[i]),
            .head_o (fifo_head[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumIds; i++) begin
                beat_q[i]   <= '0;
                wr_cnt_q[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < NumIds; i++) begin
                beat_q[i]   <= '0;
                wr_cnt_q[i] <= '0;
            end
        end else begin
            if (r_hs & ~r_empty) beat_q[r_id] <= r_pop ? '0 : r_beat + LenWidth'(1);
            for (int i = 0; i < NumIds; i++) begin
                wr_cnt_q[i] <= wr_cnt_q[i]
                             + CntW'(aw_inc & (aw_id == IdWidth'(i)))
                             - CntW'(b_dec & (b_id == IdWidth'(i)));
            end
        end
    end

    assign total_d = total_q + TotW'(rd_push) + TotW'(aw_inc) - TotW'(r_pop) - TotW'(b_dec);

`ifdef FLOO_ORDER_MON_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TimeoutCycles + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(TimeoutCycles);
    localparam logic [WdW-1:0] WdHit = WdW'(TimeoutCycles - 1);

    logic [WdW-1:0] wd_q;
    logic           wd_en, timeout_q;

    // The watchdog only runs while something is outstanding and nothing completes.
    assign wd_en      = ~(r_hs | b_hs | (total_q == '0));
    assign timeout_ev = wd_en & (wd_q >= WdHit);
    assign timeout_o  = timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if (clear_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!wd_en)             wd_q <= '0;
            else if (wd_q != WdMax) wd_q <= wd_q + WdW'(1);
            if (timeout_ev) timeout_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TimeoutCycles > 1);
    assign timeout_ev = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    // Lowest error code wins when several events coincide.
    always_comb begin
        ev_valid = 1'b1;
        ev_code  = NONE;
        ev_id    = '0;
        if (r_unexp) begin
            ev_code = R_UNEXPECTED;
            ev_id   = r_id;
        end else if (r_early) begin
            ev_code = R_LAST_EARLY;
            ev_id   = r_id;
        end else if (r_missing) begin
            ev_code = R_LAST_MISSING;
            ev_id   = r_id;
        end else if (b_unexp) begin
            ev_code = B_UNEXPECTED;
            ev_id   = b_id;
        end else if (ovf_ar) begin
            ev_code = OVERFLOW;
            ev_id   = ar_id;
        end else if (ovf_aw) begin
            ev_code = OVERFLOW;
            ev_id   = aw_id;
        end else if (timeout_ev) begin
            ev_code = TIMEOUT;
        end else begin
            ev_valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q        <= 1'b0;
            err_code_q   <= NONE;
            err_id_q     <= '0;
            num_reads_q  <= '0;
            num_writes_q <= '0;
            total_q      <= '0;
            idle_q       <= 1'b1;
        end else if (clear_i) begin
            err_q        <= 1'b0;
            err_code_q   <= NONE;
            err_id_q     <= '0;
            num_reads_q  <= '0;
            num_writes_q <= '0;
            total_q      <= '0;
            idle_q       <= 1'b1;
        end else begin
            if (!err_q && ev_valid) begin
                err_q      <= 1'b1;
                err_code_q <= ev_code;
                err_id_q   <= ev_id;
            end
            if (r_done) num_reads_q  <= sat_inc(num_reads_q);
            if (b_dec)  num_writes_q <= sat_inc(num_writes_q);
            total_q <= total_d;
            idle_q  <= (total_d == '0);
        end
    end

    assign err_o        = err_q;
    assign err_code_o   = err_code_q;
    assign err_id_o     = err_id_q;
    assign num_reads_o  = num_reads_q;
    assign num_writes_o = num_writes_q;
    assign idle_o       = idle_q;

endmodule

// File: tb/tb_floo_axi_order_monitor.sv
// Self-checking bench for floo_axi_order_monitor: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a queue-based model.
module tb_floo_axi_order_monitor;
    import floo_order_mon_pkg::*;

    localparam int IdW  = 4;
    localparam int NIds = 16;
    localparam int M    = 8;
    localparam int T    = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    mon_req_t    req;
    mon_rsp_t    rsp;
    logic        err, idle, tout;
    logic [2:0]  err_code;
    logic [3:0]  err_id;
    logic [31:0] nreads, nwrites;

    int vectors    = 0;
    int miscompares = 0;
    bit check_en   = 0;

    // Reference model state: outstanding burst lengths per ID as plain queues.
    int rdq [NIds][$];
    int beat [NIds];
    int wcnt [NIds];
    int m_err, m_code, m_id, m_reads, m_writes, m_idle, m_tout, m_wd;
    int ev_code, ev_id;

    always #5 clk = ~clk;

    floo_axi_order_monitor #(
        .IdWidth      (IdW),
        .MaxTxnsPerId (M),
        .TimeoutCycles(T),
        .req_t        (mon_req_t),
        .rsp_t        (mon_rsp_t)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .req_i       (req),
        .rsp_i       (rsp),
        .err_o       (err),
        .err_code_o  (err_code),
        .err_id_o    (err_id),
        .num_reads_o (nreads),
        .num_writes_o(nwrites),
        .idle_o      (idle),
        .timeout_o   (tout)
    );

    task automatic checkOutput(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int outstanding();
        int s = 0;
        for (int i = 0; i < NIds; i++) s += rdq[i].size() + wcnt[i];
        return s;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < NIds; i++) begin
            rdq[i].delete();
            beat[i] = 0;
            wcnt[i] = 0;
        end
        m_err = 0; m_code = 0; m_id = 0; m_reads = 0; m_writes = 0;
        m_idle = 1; m_tout = 0; m_wd = 0;
    endfunction

    function automatic void raise(input int c, input int id);
        if (ev_code == 0 || c < ev_code) begin
            ev_code = c;
            ev_id   = id;
        end
    endfunction

    function automatic void modelStep();
        bit arh, awh, rh, bh;
        int rid, arid, awid, bid, pre_out, len;
        ev_code = 0;
        ev_id   = 0;
        pre_out = outstanding();
        arh  = req.ar_valid && rsp.ar_ready;
        awh  = req.aw_valid && rsp.aw_ready;
        rh   = rsp.r_valid && req.r_ready;
        bh   = rsp.b_valid && req.b_ready;
        rid  = int'(rsp.r.id);
        arid = int'(req.ar.id);
        awid = int'(req.aw.id);
        bid  = int'(rsp.b.id);
        if (rh) begin
            if (rdq[rid].size() == 0) raise(1, rid);
            else begin
                len = rdq[rid][0];
                if (rsp.r.last && beat[rid] != len) begin
                    raise(2, rid); void'(rdq[rid].pop_front()); beat[rid] = 0;
                end else if (!rsp.r.last && beat[rid] == len) begin
                    raise(3, rid); void'(rdq[rid].pop_front()); beat[rid] = 0;
                end else if (rsp.r.last) begin
                    void'(rdq[rid].pop_front()); beat[rid] = 0; m_reads++;
                end else beat[rid]++;
            end
        end
        if (arh) begin
            if (rdq[arid].size() >= M) raise(5, arid);
            else rdq[arid].push_back(int'(req.ar.len));
        end
        if (bh) begin
            if (wcnt[bid] == 0) raise(4, bid);
            else begin wcnt[bid]--; m_writes++; end
        end
        if (awh) begin
            if (wcnt[awid] >= M) raise(5, awid);
            else wcnt[awid]++;
        end
`ifdef FLOO_ORDER_MON_TIMEOUT_EN
        if (rh || bh || pre_out == 0) m_wd = 0;
        else if (m_wd < T) m_wd++;
        if (m_wd == T) begin
            m_tout = 1;
            raise(6, 0);
        end
`else
        pre_out = pre_out + 0;
`endif
        if (m_err == 0 && ev_code != 0) begin
            m_err = 1; m_code = ev_code; m_id = ev_id;
        end
        m_idle = (outstanding() == 0) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     modelReset();
        else if (clear) modelReset();
        else            modelStep();
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("err_o vs model",        err,      m_err);
            checkOutput("err_code_o vs model",   err_code, m_code);
            checkOutput("err_id_o vs model",     err_id,   m_id);
            checkOutput("num_reads_o vs model",  nreads,   m_reads);
            checkOutput("num_writes_o vs model", nwrites,  m_writes);
            checkOutput("idle_o vs model",       idle,     m_idle);
            checkOutput("timeout_o vs model",    tout,     m_tout);
        end
    end

    task automatic applyStimulus(input bit arv, input int arid, input int arlen,
                                 input bit awv, input int awid,
                                 input bit rv, input int rid, input bit rlast,
                                 input bit bv, input int bid, input bit clr);
        @(negedge clk);
        req.ar_valid = arv; req.ar.id = 4'(arid); req.ar.len = 8'(arlen);
        req.aw_valid = awv; req.aw.id = 4'(awid);
        rsp.r_valid  = rv;  rsp.r.id  = 4'(rid);  rsp.r.last = rlast;
        rsp.b_valid  = bv;  rsp.b.id  = 4'(bid);
        rsp.ar_ready = 1'b1; rsp.aw_ready = 1'b1;
        req.r_ready  = 1'b1; req.b_ready  = 1'b1;
        clear = clr;
        @(posedge clk);
        #1;
        req.ar_valid = 1'b0; req.aw_valid = 1'b0;
        rsp.r_valid  = 1'b0; rsp.b_valid  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic sendAr(input int id, input int len); applyStimulus(1, id, len, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic sendAw(input int id);                applyStimulus(0, 0, 0, 1, id, 0, 0, 0, 0, 0, 0); endtask
    task automatic sendR(input int id, input bit last); applyStimulus(0, 0, 0, 0, 0, 1, id, last, 0, 0, 0); endtask
    task automatic sendB(input int id);                 applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, id, 0); endtask
    task automatic pulseClear();                        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic idleCycle();                         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " err_o"},        err,      0);
        checkOutput({tag, " err_code_o"},   err_code, 0);
        checkOutput({tag, " err_id_o"},     err_id,   0);
        checkOutput({tag, " num_reads_o"},  nreads,   0);
        checkOutput({tag, " num_writes_o"}, nwrites,  0);
        checkOutput({tag, " idle_o"},       idle,     1);
        checkOutput({tag, " timeout_o"},    tout,     0);
    endtask

    initial begin
        req   = '0;
        rsp   = '0;
        clear = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;
        #1;
        checkResetValues("reset");

        // Clean 4-beat burst.
        pulseClear();
        sendAr(3, 3);
        checkOutput("burst idle after AR", idle, 0);
        sendR(3, 0); sendR(3, 0); sendR(3, 0); sendR(3, 1);
        checkOutput("burst num_reads", nreads, 1);
        checkOutput("burst err_o", err, 0);
        checkOutput("burst idle", idle, 1);

        // Short response returned against the longer head burst.
        pulseClear();
        sendAr(1, 3); sendAr(1, 0);
        sendR(1, 1);
        checkOutput("early err_o", err, 1);
        checkOutput("early err_code", err_code, 2);
        checkOutput("early err_id", err_id, 1);

        // Unexpected R, then a later unexpected B must not overwrite it.
        pulseClear();
        sendR(5, 1);
        checkOutput("unexp R code", err_code, 1);
        checkOutput("unexp R id", err_id, 5);
        sendB(2);
        checkOutput("sticky code", err_code, 1);
        checkOutput("sticky id", err_id, 5);

        // Write counter overflow, then drain.
        pulseClear();
        repeat (9) sendAw(0);
        checkOutput("overflow code", err_code, 5);
        checkOutput("overflow id", err_id, 0);
        repeat (8) sendB(0);
        checkOutput("drain num_writes", nwrites, 8);
        checkOutput("drain idle", idle, 1);

        // Stalled read.
        pulseClear();
        sendAr(2, 0);
`ifdef FLOO_ORDER_MON_TIMEOUT_EN
        repeat (T - 1) idleCycle();
        checkOutput("timeout not yet", tout, 0);
        idleCycle();
        checkOutput("timeout set", tout, 1);
        checkOutput("timeout code", err_code, 6);
`else
        repeat (T + 4) idleCycle();
        checkOutput("no watchdog timeout", tout, 0);
        checkOutput("no watchdog err", err, 0);
`endif
        sendR(2, 1);

        // Clear in the middle of a burst discards it.
        pulseClear();
        sendAr(7, 3);
        sendR(7, 0);
        pulseClear();
        checkResetValues("clear");
        sendR(7, 1);
        checkOutput("post-clear code", err_code, 1);
        checkOutput("post-clear id", err_id, 7);

        // Randomized traffic on a few IDs with occasional quiet stretches.
        pulseClear();
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            req.ar_valid = ($urandom_range(0, 99) < 30);
            req.ar.id    = 4'($urandom_range(0, 3));
            req.ar.len   = 8'($urandom_range(0, 2));
            rsp.ar_ready = ($urandom_range(0, 3) != 0);
            req.aw_valid = ($urandom_range(0, 99) < 30);
            req.aw.id    = 4'($urandom_range(0, 3));
            rsp.aw_ready = ($urandom_range(0, 3) != 0);
            rsp.r_valid  = ($urandom_range(0, 99) < 40);
            rsp.r.id     = 4'($urandom_range(0, 3));
            rsp.r.last   = ($urandom_range(0, 2) == 0);
            req.r_ready  = ($urandom_range(0, 3) != 0);
            rsp.b_valid  = ($urandom_range(0, 99) < 30);
            rsp.b.id     = 4'($urandom_range(0, 3));
            req.b_ready  = ($urandom_range(0, 3) != 0);
            clear        = ($urandom_range(0, 299) == 0);
            if ((n % 600) >= 570) begin
                req.ar_valid = 1'b0; req.aw_valid = 1'b0;
                rsp.r_valid  = 1'b0; rsp.b_valid  = 1'b0;
                clear        = 1'b0;
            end
        end
        @(negedge clk);
        req.ar_valid = 1'b0; req.aw_valid = 1'b0;
        rsp.r_valid  = 1'b0; rsp.b_valid  = 1'b0;
        clear        = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/floo_axi_order_monitor.md
# floo_axi_order_monitor

Synthesizable AXI ordering and progress monitor for the master-side AXI port of a chimney with a reorder buffer. It replaces the sim-only compare and end-of-sim flow with RTL that can run in any bench or on FPGA. Per AXI ID, it tracks outstanding reads and writes and checks R burst framing against the recorded AR length, so that any cross-destination reordering of same-ID responses is detected. It also flags responses that have no matching request, flags counter overflow and provides an optional stall watchdog.

## Interface
- IdWidth, 4: AXI ID width; the monitor tracks NumIds = 2**IdWidth IDs.
- MaxTxnsPerId, 8: outstanding transactions tracked per ID per direction; must be a power of two and at least 2.
- TimeoutCycles, 1024: watchdog threshold in cycles; must be at least 2.
- req_t, logic: AXI request struct; fields used are ar.id, ar.len, aw.id, ar_valid, aw_valid, r_ready, b_ready.
- rsp_t, logic: AXI response struct; fields used are r.id, r.last, b.id, ar_ready, aw_ready, r_valid, b_valid.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear of all state, counters and errors.
- req_i  in  req_t  monitored AXI request (passive tap).
- rsp_i  in  rsp_t  monitored AXI response (passive tap).
- err_o  out  1  sticky error flag.
- err_code_o  out  3  code of the first error (floo_order_mon_pkg::err_e).
- err_id_o  out  IdWidth  AXI ID of the first error.
- num_reads_o  out  32  completed reads (R last handshakes); saturates.
- num_writes_o  out  32  completed writes (B handshakes); saturates.
- idle_o  out  1  no outstanding reads or writes.
- timeout_o  out  1  sticky watchdog flag.

## Operation
- AR handshake (ar_valid & ar_ready): push ar.len into the read FIFO of that ID.
- AW handshake: increment the write counter of that ID.
- R handshake: compare against the head entry of the r.id FIFO, using a per-ID beat counter beat_q (8 bit).
  - FIFO empty: R_UNEXPECTED.
  - r.last with beat_q != len: R_LAST_EARLY.
  - No r.last with beat_q == len: R_LAST_MISSING.
  - Otherwise, on r.last: pop the FIFO, clear beat_q and increment num_reads_o; without r.last, increment beat_q.
  - On either R error, pop the entry and clear beat_q so that checking resynchronises.
- B handshake: write counter of that ID is zero gives B_UNEXPECTED; otherwise decrement it and increment num_writes_o.
- Overflow: a push onto a full FIFO, or an AW with the counter at MaxTxnsPerId, with no same-cycle pop or decrement for that ID, gives OVERFLOW. The push is dropped.
- Error codes (err_e): NONE=0, R_UNEXPECTED=1, R_LAST_EARLY=2, R_LAST_MISSING=3, B_UNEXPECTED=4, OVERFLOW=5, TIMEOUT=6.
- Error latching: only the first error is latched. If several errors occur in one cycle, the lowest code wins and err_id_o holds the ID of that event.
- Simultaneous events on the same ID:
  - Push and pop in the same cycle are both applied.
  - An AR in the same cycle as an R on an empty FIFO still gives R_UNEXPECTED; the AR is pushed.
  - AW and B in the same cycle with the counter at zero gives B_UNEXPECTED; the counter becomes 1.
- Counter widths: per-ID write counter is $clog2(MaxTxnsPerId)+1 bits. FIFO pointers are $clog2(MaxTxnsPerId) bits with wrap-around plus a full/empty bit.

## Timing
- All outputs are registered. Effects of a handshake in cycle N are visible in cycle N+1.
- Reset and clear_i values: err_o=0, err_code_o=NONE, err_id_o=0, num_reads_o=0, num_writes_o=0, idle_o=1, timeout_o=0. All FIFOs are empty and all counters and beat_q are zero.
- clear_i has priority over every handshake in the same cycle.
- Reset asserted mid-burst discards all state; there is no recovery of in-flight transactions.
- Watchdog counter:
  - Resets to 0 on any R or B handshake, or while idle.
  - Otherwise increments and saturates.
  - Reaching TimeoutCycles sets timeout_o and, if no earlier error is latched, latches TIMEOUT.

## Configuration
- FLOO_ORDER_MON_TIMEOUT_EN defined: the watchdog is built as described above.
- Undefined: no watchdog counter is built; timeout_o is tied to 0 and TIMEOUT is never raised.

## Structure
- Package floo_order_mon_pkg holds the err_e enum (3 bit) and a localparam for the counter width of num_reads_o and num_writes_o (32).
- Sub-module floo_order_mon_len_fifo: per-ID FIFO of depth MaxTxnsPerId and width 8, with push, pop, full, empty and head outputs. The top instantiates one per ID via generate.

## Test plan
- AR id=3 len=3, then four R beats id=3 with last on beat 4: num_reads_o=1, err_o=0, idle_o=1 one cycle after the last beat.
- AR id=1 len=3 and AR id=1 len=0, with responses returned as a single-beat R id=1 last first: err_code_o=2 (R_LAST_EARLY), err_id_o=1.
- R id=5 with no prior AR: err_code_o=1, err_id_o=5; a later B id=2 without an AW leaves the code at 1.
- Nine AWs on id=0 with MaxTxnsPerId=8 and no B: err_code_o=5. Then eight B id=0: num_writes_o=8, idle_o=1.
- With the macro defined and TimeoutCycles=16: one AR is issued and R is withheld. timeout_o=1 and err_code_o=6 after 16 cycles. Without the macro, timeout_o stays 0.
- clear_i pulsed during an outstanding burst: all outputs return to reset values the next cycle, and a following R beat reports R_UNEXPECTED.
